// File: rtl/rv32_cpu_pkg.sv
// Shared RV32 CPU definitions: issue-aligner state encodings, the 32-bit length marker
// and the PC step sizes for 16-bit and 32-bit instructions.
package rv32_cpu_pkg;

  typedef enum logic [1:0] {
    S_ALIGN = 2'd0,
    S_HALF  = 2'd1,
    S_SKIP  = 2'd2
  } state_e;

  localparam logic [1:0]  ISA_LEN32 = 2'b11;
  localparam logic [31:0] PC_STEP16 = 32'd2;
  localparam logic [31:0] PC_STEP32 = 32'd4;

endpackage

// File: rtl/rv32_cpu_issue_aligner.sv
// Issue aligner: slices 32-bit aligned fetch words into 16/32-bit instructions with PC.
// Define RV32_ISSUE_C_EN for compressed support; otherwise every word issues as 32-bit.
module rv32_cpu_issue_aligner
  import rv32_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_data,
  input  logic        i_fetch_err,
  output logic        o_fetch_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic        o_comp,
  output logic        o_err,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic        w_xfer;

  assign o_pc   = r_pc;
  assign w_xfer = o_valid & i_ready;

`ifdef RV32_ISSUE_C_EN
  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_hbuf;
  logic        r_hbuf_err;
  logic        w_load_hbuf;
  logic        w_word_len32;
  logic        w_hbuf_comp;

  // An errored word is issued whole so the fault is reported at its own PC.
  assign w_word_len32 = (i_fetch_data[1:0] == ISA_LEN32) | i_fetch_err;
  assign w_hbuf_comp  = r_hbuf_err | (r_hbuf[1:0] != ISA_LEN32);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    o_valid       = 1'b0;
    o_instr       = '0;
    o_comp        = 1'b0;
    o_err         = 1'b0;
    o_fetch_ready = 1'b0;
    w_load_hbuf   = 1'b0;
    w_state_nxt   = r_state;
    unique case (r_state)
      S_ALIGN: begin
        o_valid       = i_fetch_valid;
        o_instr       = w_word_len32 ? i_fetch_data : {16'h0000, i_fetch_data[15:0]};
        o_comp        = ~w_word_len32;
        o_err         = i_fetch_err;
        o_fetch_ready = i_fetch_valid & i_ready;
        if (o_fetch_ready && !w_word_len32) begin
          w_load_hbuf = 1'b1;
          w_state_nxt = S_HALF;
        end
      end
      S_HALF: begin
        if (w_hbuf_comp) begin
          o_valid = 1'b1;
          o_instr = {16'h0000, r_hbuf};
          o_comp  = 1'b1;
          o_err   = r_hbuf_err;
          if (i_ready) w_state_nxt = S_ALIGN;
        end else begin
          // Straddling instruction: low half buffered, high half from the new word.
          o_valid       = i_fetch_valid;
          o_instr       = {i_fetch_data[15:0], r_hbuf};
          o_err         = r_hbuf_err | i_fetch_err;
          o_fetch_ready = i_fetch_valid & i_ready;
          w_load_hbuf   = o_fetch_ready;
        end
      end
      S_SKIP: begin
        o_fetch_ready = i_fetch_valid;
        w_load_hbuf   = i_fetch_valid;
        if (i_fetch_valid) w_state_nxt = S_HALF;
      end
      default: w_state_nxt = S_ALIGN;
    endcase
    if (i_redirect) begin
      o_valid       = 1'b0;
      o_fetch_ready = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pc       <= RESET_PC;
      r_state    <= S_ALIGN;
      r_hbuf     <= '0;
      r_hbuf_err <= 1'b0;
    end else if (i_redirect) begin
      r_pc       <= i_redirect_pc & ~32'd1;
      r_hbuf_err <= 1'b0;
      r_state    <= i_redirect_pc[1] ? S_SKIP : S_ALIGN;
    end else begin
      if (w_xfer) r_pc <= r_pc + (o_comp ? PC_STEP16 : PC_STEP32);
      if (w_load_hbuf) begin
        r_hbuf     <= i_fetch_data[31:16];
        r_hbuf_err <= i_fetch_err;
      end
      r_state <= w_state_nxt;
    end
  end

`else
  always_comb begin
    o_valid       = i_fetch_valid & ~i_redirect;
    o_fetch_ready = i_fetch_valid & i_ready & ~i_redirect;
    o_instr       = i_fetch_data;
    o_comp        = 1'b0;
    o_err         = i_fetch_err;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)         r_pc <= RESET_PC;
    else if (i_redirect) r_pc <= i_redirect_pc & ~32'd3;
    else if (w_xfer)     r_pc <= r_pc + PC_STEP32;
  end
`endif

endmodule

// File: tb/tb_rv32_cpu_issue_aligner.sv
// Scoreboard bench for rv32_cpu_issue_aligner; expectations follow RV32_ISSUE_C_EN.
module tb_rv32_cpu_issue_aligner;

  typedef struct packed {
    logic [31:0] instr;
    logic        comp;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fw_t;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_fetch_valid = 1'b0;
  logic [31:0] i_fetch_data = '0;
  logic        i_fetch_err = 1'b0;
  logic        o_fetch_ready;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_instr;
  logic        o_comp;
  logic        o_err;
  logic [31:0] o_pc;

  exp_t exp_q[$];
  fw_t  fq[$];
  int   total = 0;
  int   bad = 0;
  int   pops = 0;

  rv32_cpu_issue_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_fetch_valid(i_fetch_valid), .i_fetch_data(i_fetch_data), .i_fetch_err(i_fetch_err),
    .o_fetch_ready(o_fetch_ready), .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
    .o_comp(o_comp), .o_err(o_err), .o_pc(o_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction is matched against the head of the scoreboard.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rstn && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got instr=%h pc=%h want no output", o_instr, o_pc);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", o_instr, e.instr);
        check("out_comp", {31'd0, o_comp}, {31'd0, e.comp});
        check("out_err", {31'd0, o_err}, {31'd0, e.err});
        check("out_pc", o_pc, e.pc);
      end
    end
  end

  task automatic drive_fetch();
    if (fq.size() > 0) begin
      i_fetch_valid = 1'b1;
      i_fetch_data  = fq[0].data;
      i_fetch_err   = fq[0].err;
    end else begin
      i_fetch_valid = 1'b0;
      i_fetch_data  = '0;
      i_fetch_err   = 1'b0;
    end
  endtask

  task automatic step();
    logic pop;
    @(negedge i_clk);
    pop = i_fetch_valid && o_fetch_ready;
    @(posedge i_clk);
    #1;
    if (pop && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    drive_fetch();
  endtask

  task automatic push_word(input logic [31:0] d, input logic e);
    fq.push_back('{data: d, err: e});
    drive_fetch();
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic comp, input logic err,
                          input logic [31:0] pc);
    exp_q.push_back('{instr: instr, comp: comp, err: err, pc: pc});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Redirect with whatever word is currently presented; upstream flushes alongside.
  task automatic redirect(input logic [31:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    #1;
    check("redir_valid", {31'd0, o_valid}, 32'd0);
    check("redir_pop", {31'd0, o_fetch_ready}, 32'd0);
    step();
    i_redirect = 1'b0;
    fq.delete();
    drive_fetch();
    pops = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w_inst, w_pc;
    logic        w_comp;

    // Reset state
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_fetch_ready", {31'd0, o_fetch_ready}, 32'd0);
    check("rst_pc", o_pc, 32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;

    // Test 1: two ADDI words from pc 0
    push_exp(32'h0000_0013, 1'b0, 1'b0, 32'h0);
    push_exp(32'h0000_0093, 1'b0, 1'b0, 32'h4);
    push_word(32'h0000_0013, 1'b0);
    push_word(32'h0000_0093, 1'b0);
    drain(50);
    check("t1_pops", pops, 32'd2);

    // Test 2: two C.LI in one word
    redirect(32'h0);
`ifdef RV32_ISSUE_C_EN
    push_exp(32'h0000_4501, 1'b1, 1'b0, 32'h0);
    push_exp(32'h0000_4505, 1'b1, 1'b0, 32'h2);
`else
    push_exp(32'h4505_4501, 1'b0, 1'b0, 32'h0);
`endif
    push_word(32'h4505_4501, 1'b0);
    drain(50);
    step();
    check("t2_pops", pops, 32'd1);

    // Test 3: compressed, straddling 32-bit, compressed
    redirect(32'h0);
`ifdef RV32_ISSUE_C_EN
    push_exp(32'h0000_4501, 1'b1, 1'b0, 32'h0);
    push_exp(32'h0000_0013, 1'b0, 1'b0, 32'h2);
    push_exp(32'h0000_4501, 1'b1, 1'b0, 32'h6);
`else
    push_exp(32'h0013_4501, 1'b0, 1'b0, 32'h0);
    push_exp(32'h4501_0000, 1'b0, 1'b0, 32'h4);
`endif
    push_word(32'h0013_4501, 1'b0);
    push_word(32'h4501_0000, 1'b0);
    drain(50);
    check("t3_pops", pops, 32'd2);

    // Test 5: bus error on the second word
    redirect(32'h0);
`ifdef RV32_ISSUE_C_EN
    push_exp(32'h0000_4501, 1'b1, 1'b0, 32'h0);
    push_exp(32'h0000_0013, 1'b0, 1'b1, 32'h2);
    push_exp(32'h0000_4501, 1'b1, 1'b1, 32'h6);
`else
    push_exp(32'h0013_4501, 1'b0, 1'b0, 32'h0);
    push_exp(32'h4501_0000, 1'b0, 1'b1, 32'h4);
`endif
    push_word(32'h0013_4501, 1'b0);
    push_word(32'h4501_0000, 1'b1);
    drain(50);

    // Test 4: redirect to 0x102 while a word is presented
    push_word(32'h0013_0001, 1'b0);
    redirect(32'h0000_0102);
    push_word(32'h0013_0001, 1'b0);
`ifdef RV32_ISSUE_C_EN
    step();
    step();
    step();
    #1;
    check("t4_wait_valid", {31'd0, o_valid}, 32'd0);
    check("t4_wait_pop", {31'd0, o_fetch_ready}, 32'd0);
    check("t4_skip_pops", pops, 32'd1);
    push_exp(32'h0093_0013, 1'b0, 1'b0, 32'h0000_0102);
    push_word(32'h0000_0093, 1'b0);
    drain(20);
    i_ready = 1'b0;
    w_inst = 32'h0;
    w_comp = 1'b1;
    w_pc   = 32'h0000_0106;
`else
    push_exp(32'h0013_0001, 1'b0, 1'b0, 32'h0000_0100);
    push_exp(32'h0000_0093, 1'b0, 1'b0, 32'h0000_0104);
    push_word(32'h0000_0093, 1'b0);
    drain(20);
    i_ready = 1'b0;
    push_word(32'h0000_0000, 1'b0);
    w_inst = 32'h0;
    w_comp = 1'b0;
    w_pc   = 32'h0000_0108;
`endif
    #1;
    check("t4_pend_valid", {31'd0, o_valid}, 32'd1);
    check("t4_pend_instr", o_instr, w_inst);
    check("t4_pend_comp", {31'd0, o_comp}, {31'd0, w_comp});
    check("t4_pend_pc", o_pc, w_pc);
    redirect(32'h0000_0200);
    #1;
    check("t4_after_redir_valid", {31'd0, o_valid}, 32'd0);
    check("t4_after_redir_pc", o_pc, 32'h0000_0200);
    i_ready = 1'b1;

    // Test 6: backpressure then async reset mid-stream
    redirect(32'h0);
    i_ready = 1'b0;
`ifdef RV32_ISSUE_C_EN
    push_exp(32'h0000_4501, 1'b1, 1'b0, 32'h0);
    push_exp(32'h0000_0013, 1'b0, 1'b0, 32'h2);
    push_exp(32'h0000_4501, 1'b1, 1'b0, 32'h6);
    w_inst = 32'h0000_4501;
`else
    push_exp(32'h0013_4501, 1'b0, 1'b0, 32'h0);
    push_exp(32'h4501_0000, 1'b0, 1'b0, 32'h4);
    w_inst = 32'h0013_4501;
`endif
    push_word(32'h0013_4501, 1'b0);
    push_word(32'h4501_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check("t6_stall_instr", o_instr, w_inst);
      check("t6_stall_pc", o_pc, 32'h0);
      check("t6_stall_pop", {31'd0, o_fetch_ready}, 32'd0);
    end
    i_ready = 1'b1;
    drain(50);

    redirect(32'h0);
`ifdef RV32_ISSUE_C_EN
    push_exp(32'h0000_4501, 1'b1, 1'b0, 32'h0);
`else
    push_exp(32'h0013_4501, 1'b0, 1'b0, 32'h0);
`endif
    push_word(32'h0013_4501, 1'b0);
    push_word(32'h4501_0000, 1'b0);
    step();
    #1;
    i_rstn = 1'b0;
    fq.delete();
    drive_fetch();
    #1;
    check("t6_rst_pc", o_pc, 32'h0);
    check("t6_rst_valid", {31'd0, o_valid}, 32'd0);
    check("t6_rst_drop", exp_q.size(), 32'd0);
    step();
    i_rstn = 1'b1;
    push_exp(32'h0000_0013, 1'b0, 1'b0, 32'h0);
    push_word(32'h0000_0013, 1'b0);
    drain(50);
    step();

    check("final_scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
